// File: rtl/bram_arbiter.sv
// Shares the single BRAM port between CPU single-word accesses and video read bursts.
// Read data comes back one cycle after the grant and is tagged to the requester.
module bram_arbiter #(
  parameter int DEPTH = 24576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [3:0]  cpu_be,
  input  logic [14:0] cpu_adr,
  input  logic [31:0] cpu_wd,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rd,
  output logic        cpu_err,
  input  logic        vid_req,
  input  logic [14:0] vid_adr,
  input  logic [3:0]  vid_len,
  output logic        vid_rvalid,
  output logic [31:0] vid_rd,
  output logic        vid_done,
  output logic [14:0] adra,
  output logic [3:0]  bea,
  output logic        wea,
  output logic [31:0] wda,
  input  logic [31:0] rda
);

  typedef enum logic [1:0] {IDLE, VBURST, VDRAIN} state_e;

  localparam logic [15:0] DepthW = 16'(DEPTH);

  state_e      state_q, state_d;
  logic [14:0] vaddr_q, vaddr_d;
  logic [3:0]  vcnt_q, vcnt_d;
  logic        lastVid_q;
  logic        rdCpu_q, rdVid_q, rdOor_q, rdLast_q;
  logic [14:0] adra_q;

  logic cpuGnt, vidGnt;
  logic cpuOor, vidOor;
  logic vidDoneInFlight;

  assign cpuOor          = {1'b0, cpu_adr} >= DepthW;
  assign vidOor          = {1'b0, vaddr_q} >= DepthW;
  assign vidDoneInFlight = rdVid_q & rdLast_q;

  // State, burst counters and the one-deep read tag for the data returning next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      vaddr_q   <= '0;
      vcnt_q    <= '0;
      lastVid_q <= 1'b0;
      rdCpu_q   <= 1'b0;
      rdVid_q   <= 1'b0;
      rdOor_q   <= 1'b0;
      rdLast_q  <= 1'b0;
      adra_q    <= '0;
    end else begin
      state_q   <= state_d;
      vaddr_q   <= vaddr_d;
      vcnt_q    <= vcnt_d;
      lastVid_q <= vidGnt;
      rdCpu_q   <= cpuGnt & ~cpu_we;
      rdVid_q   <= vidGnt;
      rdOor_q   <= cpuGnt ? cpuOor : vidOor;
      rdLast_q  <= vidGnt & (vcnt_q == 4'd0);
      adra_q    <= adra;
    end
  end

  // Grants are qualified by reset so an asserted reset silences the BRAM port at once.
  always_comb begin
    state_d = state_q;
    vaddr_d = vaddr_q;
    vcnt_d  = vcnt_q;
    cpuGnt  = 1'b0;
    vidGnt  = 1'b0;
    if (rst) begin
      case (state_q)
        IDLE: begin
          if (cpu_req) begin
            cpuGnt = 1'b1;
          end else if (vid_req && !vidDoneInFlight) begin
            vaddr_d = vid_adr;
            vcnt_d  = vid_len;
            state_d = VBURST;
          end
        end
        VBURST: begin
          if (cpu_req && lastVid_q) begin
            cpuGnt = 1'b1;
          end else begin
            vidGnt  = 1'b1;
            vaddr_d = vaddr_q + 15'd1;
            vcnt_d  = vcnt_q - 4'd1;
            if (vcnt_q == 4'd0) state_d = VDRAIN;
          end
        end
        VDRAIN: begin
          cpuGnt  = cpu_req;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    adra = adra_q;
    bea  = 4'b0000;
    wea  = 1'b0;
    wda  = 32'h0;
    if (cpuGnt) begin
      adra = cpu_adr;
      if (cpu_we) begin
        bea = cpu_be;
        wea = ~cpuOor;
        wda = cpu_wd;
      end
    end else if (vidGnt) begin
      adra = vaddr_q;
    end
    cpu_gnt    = cpuGnt;
    cpu_rvalid = rdCpu_q;
    cpu_rd     = (rdCpu_q && !rdOor_q) ? rda : 32'h0;
    cpu_err    = (cpuGnt & cpu_we & cpuOor) | (rdCpu_q & rdOor_q);
    vid_rvalid = rdVid_q;
    vid_rd     = (rdVid_q && !rdOor_q) ? rda : 32'h0;
    vid_done   = rdVid_q & rdLast_q;
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter: a BRAM model plus a reference memory feed
// per-requester scoreboards that are checked whenever read data comes back.
module tb_bram_arbiter;

  localparam int DEPTH = 24576;

  logic        clk = 1'b0;
  logic        rstN;
  logic        cpuReq, cpuWe;
  logic [3:0]  cpuBe;
  logic [14:0] cpuAdr;
  logic [31:0] cpuWd;
  logic        cpuGnt, cpuRvalid, cpuErr;
  logic [31:0] cpuRd;
  logic        vidReq;
  logic [14:0] vidAdr;
  logic [3:0]  vidLen;
  logic        vidRvalid, vidDone;
  logic [31:0] vidRd;
  logic [14:0] adra;
  logic [3:0]  bea;
  logic        wea;
  logic [31:0] wda;
  logic [31:0] rda = 32'h0;

  logic [31:0] mem    [0:32767];
  logic [31:0] refMem [0:32767];
  logic [32:0] cpuQ[$];
  logic [32:0] vidQ[$];

  int total = 0;
  int bad   = 0;

  bram_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rstN),
    .cpu_req(cpuReq), .cpu_we(cpuWe), .cpu_be(cpuBe), .cpu_adr(cpuAdr), .cpu_wd(cpuWd),
    .cpu_gnt(cpuGnt), .cpu_rvalid(cpuRvalid), .cpu_rd(cpuRd), .cpu_err(cpuErr),
    .vid_req(vidReq), .vid_adr(vidAdr), .vid_len(vidLen),
    .vid_rvalid(vidRvalid), .vid_rd(vidRd), .vid_done(vidDone),
    .adra(adra), .bea(bea), .wea(wea), .wda(wda), .rda(rda)
  );

  always #5 clk = ~clk;

  // Single-port BRAM model with one-cycle registered read.
  always @(posedge clk) begin
    if (wea)
      for (int b = 0; b < 4; b++)
        if (bea[b]) mem[adra][8*b +: 8] <= wda[8*b +: 8];
    rda <= mem[adra];
  end

  // Scoreboard: every returned word must match the oldest expectation of its requester.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rstN) begin
      if (cpuRvalid) begin
        total++;
        if (cpuQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL cpu_unexpected_rvalid: got rd=%h err=%b, required no rvalid", cpuRd, cpuErr);
        end else begin
          e = cpuQ.pop_front();
          if ({cpuRd, cpuErr} !== e) begin
            bad++;
            $display("[TB] FAIL cpu_read_data: got rd=%h err=%b, required rd=%h err=%b", cpuRd, cpuErr, e[32:1], e[0]);
          end
        end
      end
      if (vidRvalid) begin
        total++;
        if (vidQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL vid_unexpected_rvalid: got rd=%h done=%b, required no rvalid", vidRd, vidDone);
        end else begin
          e = vidQ.pop_front();
          if ({vidRd, vidDone} !== e) begin
            bad++;
            $display("[TB] FAIL vid_read_data: got rd=%h done=%b, required rd=%h done=%b", vidRd, vidDone, e[32:1], e[0]);
          end
        end
      end else if (vidDone) begin
        total++;
        bad++;
        $display("[TB] FAIL vid_done_alone: got vid_done=1 without vid_rvalid, required 0");
      end
    end
  end

  task automatic test_cpu_access(input logic we, input logic [3:0] be, input logic [14:0] adr,
                                 input logic [31:0] wd);
    int waited;
    logic oor;
    oor = int'(adr) >= DEPTH;
    @(posedge clk); #1;
    cpuReq = 1'b1; cpuWe = we; cpuBe = be; cpuAdr = adr; cpuWd = wd;
    if (!we) cpuQ.push_back({oor ? 32'h0 : refMem[adr], oor});
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!cpuGnt && waited < 8);
    total++;
    if (!cpuGnt || waited > 2) begin
      bad++;
      $display("[TB] FAIL cpu_grant_latency: got gnt=%b after %0d cycles, required gnt within 2", cpuGnt, waited);
    end
    if (we) begin
      total++;
      if ({wea, cpuErr} !== {~oor, oor}) begin
        bad++;
        $display("[TB] FAIL cpu_write_en: got wea=%b err=%b, required wea=%b err=%b", wea, cpuErr, ~oor, oor);
      end
      total++;
      if ({adra, bea, wda} !== {adr, be, wd}) begin
        bad++;
        $display("[TB] FAIL cpu_write_bus: got adra=%h bea=%b wda=%h, required adra=%h bea=%b wda=%h",
                 adra, bea, wda, adr, be, wd);
      end
      if (!oor)
        for (int b = 0; b < 4; b++)
          if (be[b]) refMem[adr][8*b +: 8] = wd[8*b +: 8];
    end else begin
      total++;
      if ({adra, bea, wea, cpuErr} !== {adr, 4'b0000, 1'b0, 1'b0}) begin
        bad++;
        $display("[TB] FAIL cpu_read_bus: got adra=%h bea=%b wea=%b err=%b, required adra=%h bea=0 wea=0 err=0",
                 adra, bea, wea, cpuErr, adr);
      end
    end
    @(posedge clk); #1;
    cpuReq = 1'b0;
    if (!we) begin
      @(negedge clk);
      total++;
      if (cpuRvalid !== 1'b1) begin
        bad++;
        $display("[TB] FAIL cpu_read_latency: got rvalid=%b one cycle after grant, required 1", cpuRvalid);
      end
    end
  endtask

  task automatic test_reset;
    rstN = 1'b0;
    cpuReq = 1'b1; vidReq = 1'b1;
    #1;
    total++;
    if ({cpuGnt, cpuRvalid, cpuErr, vidRvalid, vidDone, cpuRd, vidRd, adra, bea, wea, wda} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got gnt=%b rv=%b err=%b vrv=%b done=%b adra=%h bea=%b wea=%b wda=%h, required all 0",
               cpuGnt, cpuRvalid, cpuErr, vidRvalid, vidDone, adra, bea, wea, wda);
    end
    cpuReq = 1'b0; vidReq = 1'b0;
    @(posedge clk); #1;
    rstN = 1'b1;
    @(negedge clk);
    total++;
    if ({cpuGnt, vidRvalid, wea} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL reset_idle: got gnt=%b vrv=%b wea=%b, required 0", cpuGnt, vidRvalid, wea);
    end
  endtask

  task automatic test_cpu_write_read;
    test_cpu_access(1'b1, 4'b0101, 15'h0010, 32'hAABBCCDD);
    test_cpu_access(1'b0, 4'b1111, 15'h0010, 32'h0);
    test_cpu_access(1'b1, 4'b1010, 15'h0020, 32'h01234567);
    test_cpu_access(1'b0, 4'b0000, 15'h0020, 32'h0);
  endtask

  task automatic test_out_of_range;
    test_cpu_access(1'b0, 4'b0000, 15'd24576, 32'h0);
    test_cpu_access(1'b1, 4'b1111, 15'd24600, 32'hDEADBEEF);
    test_cpu_access(1'b1, 4'b1111, 15'd24575, 32'hCAFEF00D);
    test_cpu_access(1'b0, 4'b0000, 15'd24575, 32'h0);
  endtask

  task automatic test_video_burst(input logic [14:0] adr, input logic [3:0] len);
    int c, rv, firstRv, lastRv, doneAt;
    logic errSeen;
    logic [14:0] a;
    for (int k = 0; k <= int'(len); k++) begin
      a = adr + 15'(k);
      vidQ.push_back({(int'(a) >= DEPTH) ? 32'h0 : refMem[a], k == int'(len)});
    end
    @(posedge clk); #1;
    vidReq = 1'b1; vidAdr = adr; vidLen = len;
    c = 0; rv = 0; firstRv = -1; lastRv = -1; doneAt = -1; errSeen = 1'b0;
    while (doneAt < 0 && c < 60) begin
      @(negedge clk);
      c++;
      if (vidRvalid) begin
        rv++;
        if (firstRv < 0) firstRv = c;
        lastRv = c;
      end
      if (cpuErr) errSeen = 1'b1;
      if (c == 2 || c == 3) begin
        total++;
        if (adra !== adr + 15'(c - 2)) begin
          bad++;
          $display("[TB] FAIL vid_issue_addr: got adra=%h at cycle %0d, required %h", adra, c, adr + 15'(c - 2));
        end
      end
      if (vidDone) doneAt = c;
    end
    @(posedge clk); #1;
    vidReq = 1'b0;
    total++;
    if (doneAt != int'(len) + 3) begin
      bad++;
      $display("[TB] FAIL vid_burst_time: got done at cycle %0d, required %0d", doneAt, int'(len) + 3);
    end
    total++;
    if (rv != int'(len) + 1 || lastRv - firstRv != int'(len)) begin
      bad++;
      $display("[TB] FAIL vid_rvalid_run: got %0d rvalids over span %0d, required %0d consecutive",
               rv, lastRv - firstRv, int'(len) + 1);
    end
    total++;
    if (errSeen !== 1'b0) begin
      bad++;
      $display("[TB] FAIL vid_no_cpu_err: got cpu_err=1 during burst, required 0");
    end
  endtask

  task automatic test_interleave;
    int c, doneAt, vrv, waited, cGrants;
    logic [14:0] nextAdr;
    logic gntSeen;
    for (int k = 0; k < 16; k++) vidQ.push_back({refMem[15'h0200 + 15'(k)], k == 15});
    nextAdr = 15'h0300;
    @(posedge clk); #1;
    vidReq = 1'b1; vidAdr = 15'h0200; vidLen = 4'd15;
    c = 0; doneAt = -1; vrv = 0; waited = 0; cGrants = 0;
    while (c < 100) begin
      @(negedge clk);
      if (cpuReq) waited++;
      gntSeen = cpuGnt;
      if (vidRvalid) vrv++;
      if (c >= 1 && c <= 32) begin
        total++;
        if (cpuGnt !== ((c % 2) == 0)) begin
          bad++;
          $display("[TB] FAIL alternation: got cpu_gnt=%b at cycle %0d, required %b", cpuGnt, c, (c % 2) == 0);
        end
      end
      if (cpuGnt) begin
        cGrants++;
        total++;
        if (waited > 2) begin
          bad++;
          $display("[TB] FAIL cpu_wait_in_burst: got %0d cycles, required at most 2", waited);
        end
      end
      if (vidDone) doneAt = c;
      @(posedge clk); #1;
      if (c == 0) begin
        cpuReq = 1'b1; cpuWe = 1'b0; cpuAdr = nextAdr; waited = 0;
        cpuQ.push_back({refMem[nextAdr], 1'b0});
      end else if (doneAt >= 0) begin
        cpuReq = 1'b0; vidReq = 1'b0;
        break;
      end else if (gntSeen) begin
        nextAdr = nextAdr + 15'd1;
        cpuAdr = nextAdr; waited = 0;
        cpuQ.push_back({refMem[nextAdr], 1'b0});
      end
      c++;
    end
    @(negedge clk);
    total++;
    if (doneAt != 32 || vrv != 16) begin
      bad++;
      $display("[TB] FAIL interleave_burst: got done at %0d with %0d rvalids, required 32 and 16", doneAt, vrv);
    end
    total++;
    if (cGrants != 16) begin
      bad++;
      $display("[TB] FAIL interleave_cpu_grants: got %0d, required 16", cGrants);
    end
  endtask

  task automatic test_async_reset;
    int seen;
    for (int k = 0; k < 16; k++) vidQ.push_back({refMem[15'h0400 + 15'(k)], k == 15});
    @(posedge clk); #1;
    vidReq = 1'b1; vidAdr = 15'h0400; vidLen = 4'd15;
    repeat (3) @(posedge clk);
    #2;
    rstN = 1'b0;
    #1;
    total++;
    if ({cpuGnt, cpuRvalid, cpuErr, vidRvalid, vidDone, cpuRd, vidRd, adra, bea, wea, wda} !== '0) begin
      bad++;
      $display("[TB] FAIL async_reset_outputs: got vrv=%b done=%b vrd=%h adra=%h bea=%b wea=%b, required all 0",
               vidRvalid, vidDone, vidRd, adra, bea, wea);
    end
    vidReq = 1'b0;
    vidQ.delete();
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (vidRvalid || vidDone) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("[TB] FAIL post_reset_quiet: got %0d video responses, required 0", seen);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32768; i++) begin
      mem[i]    = (i * 32'h00010001) ^ 32'hC3C30F0F;
      refMem[i] = mem[i];
    end
    mem[16'h0010]    = 32'h11223344;
    refMem[16'h0010] = 32'h11223344;
    cpuReq = 1'b0; cpuWe = 1'b0; cpuBe = 4'h0; cpuAdr = '0; cpuWd = '0;
    vidReq = 1'b0; vidAdr = '0; vidLen = '0;
    rstN = 1'b0;
    #12;
    test_reset;
    test_cpu_write_read;
    test_out_of_range;
    test_video_burst(15'h0100, 4'd3);
    test_video_burst(15'h7FFF, 4'd1);
    test_interleave;
    test_async_reset;
    repeat (2) @(negedge clk);
    total++;
    if (cpuQ.size() != 0 || vidQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drained: got cpu=%0d vid=%0d pending, required 0", cpuQ.size(), vidQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
